// File: rtl/tx_serial_cfg_pkg.sv
// Shared constants and helpers for the configurable serial transmitter.
// State encoding, parity modes and frame-length arithmetic.
package tx_serial_pkg;

   localparam logic [1:0] INICIAL     = 2'd0;
   localparam logic [1:0] TRANSMISSAO = 2'd1;
   localparam logic [1:0] FINAL       = 2'd2;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   function automatic int frame_len(
      input int db,
      input int par,
      input int sb
   );
      return 1 + db + ((par != PAR_NONE) ? 1 : 0) + sb;
   endfunction

   function automatic logic parity_bit(
      input logic [7:0] d,
      input int         par
   );
      return (par == PAR_ODD) ? ~^d : ^d;
   endfunction

endpackage

// File: rtl/tx_serial_cfg_if.sv
// Start/ready handshake and serial line bundle of the transmitter.
// The DUT takes the slave side, the requester the master side.
interface tx_serial_cfg_if #(
   parameter int DATA_BITS = 7
);
   logic                 partida;
   logic [DATA_BITS-1:0] dados;
   logic                 saida_serial;
   logic                 ocupado;
   logic                 pronto;
   logic [1:0]           db_estado;

   modport master (
      output partida, dados,
      input  saida_serial, ocupado, pronto, db_estado
   );

   modport slave (
      input  partida, dados,
      output saida_serial, ocupado, pronto, db_estado
   );
endinterface

// File: rtl/tx_serial_cfg_contador.sv
// Modulo-M counter with synchronous clear and count enable.
// fim flags the terminal count M-1.
module contador_m #(
   parameter int M = 16,
   parameter int N = 4
) (
   input  logic clock,
   input  logic zera_s,
   input  logic conta,
   output logic fim
);
   logic [N-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (zera_s)
         q_d = '0;
      else if (conta)
         q_d = (q_q == N'(M-1)) ? '0 : q_q + N'(1);
   end

   always_ff @(posedge clock)
      q_q <= q_d;

   assign fim = (q_q == N'(M-1));
endmodule

// File: rtl/tx_serial_cfg.sv
// Configurable async serial transmitter: start, data LSB-first,
// optional parity, 1-2 stop bits, fixed baud divider.
module tx_serial_cfg
   import tx_serial_pkg::*;
#(
   parameter int DATA_BITS = 7,
   parameter int PARITY    = 1,
   parameter int STOP_BITS = 1,
   parameter int BAUD_DIV  = 434
) (
   input logic           clock,
   input logic           reset,
   tx_serial_cfg_if.slave tx
);
   localparam int NF = frame_len(DATA_BITS, PARITY, STOP_BITS);
   localparam int BW = $clog2(BAUD_DIV);

   generate
      if (DATA_BITS < 5 || DATA_BITS > 8 ||
          PARITY < 0 || PARITY > 2 ||
          STOP_BITS < 1 || STOP_BITS > 2 ||
          BAUD_DIV < 2) begin : g_bad_param
         $error("tx_serial_cfg: illegal parameter value");
      end
   endgenerate

   logic [1:0]    estado_q, estado_d;
   logic [NF-1:0] shift_q, shift_d, frame;
   logic          saida_q, ocupado_q, pronto_q;
   logic [1:0]    db_q;
   logic          em_tx, baud_fim, bit_fim;

   assign em_tx = (estado_q == TRANSMISSAO);

   contador_m #(.M(BAUD_DIV), .N(BW)) u_baud (
      .clock  (clock),
      .zera_s (reset | ~em_tx),
      .conta  (em_tx),
      .fim    (baud_fim)
   );

   contador_m #(.M(NF), .N(4)) u_bit (
      .clock  (clock),
      .zera_s (reset | ~em_tx),
      .conta  (em_tx & baud_fim),
      .fim    (bit_fim)
   );

   // Stop bits fill from the all-ones default
   always_comb begin
      frame = '1;
      frame[0] = 1'b0;
      frame[DATA_BITS:1] = tx.dados;
      if (PARITY != PAR_NONE)
         frame[DATA_BITS+1] = parity_bit(8'(tx.dados), PARITY);
   end

   always_comb begin
      estado_d = estado_q;
      shift_d  = shift_q;
      unique case (estado_q)
         INICIAL: begin
            if (tx.partida) begin
               estado_d = TRANSMISSAO;
               shift_d  = frame;
            end
         end
         TRANSMISSAO: begin
            if (baud_fim) begin
               shift_d = {1'b1, shift_q[NF-1:1]};
               if (bit_fim)
                  estado_d = FINAL;
            end
         end
         FINAL:   estado_d = INICIAL;
         default: estado_d = INICIAL;
      endcase
   end

   // Outputs lag the state by one register stage
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q  <= INICIAL;
         shift_q   <= '1;
         saida_q   <= 1'b1;
         ocupado_q <= 1'b0;
         pronto_q  <= 1'b0;
         db_q      <= INICIAL;
      end else begin
         estado_q  <= estado_d;
         shift_q   <= shift_d;
         saida_q   <= em_tx ? shift_q[0] : 1'b1;
         ocupado_q <= (estado_q != INICIAL);
         pronto_q  <= (estado_q == FINAL);
         db_q      <= estado_q;
      end
   end

   assign tx.saida_serial = saida_q;
   assign tx.ocupado      = ocupado_q;
   assign tx.pronto       = pronto_q;
   assign tx.db_estado    = db_q;
endmodule

// File: tb/tb_tx_serial_cfg.sv
// Bench for tx_serial_cfg: three parameter sets against a
// cycle-level frame model derived from the line timing rules.
module tb_tx_serial_cfg;

   localparam int DBV[3]  = '{7, 8, 5};
   localparam int PARV[3] = '{1, 2, 0};
   localparam int SBV[3]  = '{1, 2, 1};
   localparam int BDV[3]  = '{4, 4, 3};

   logic       clk = 1'b0;
   logic       rst;
   logic       partida;
   logic [7:0] dados;
   int         sel;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   tx_serial_cfg_if #(.DATA_BITS(7)) ifa ();
   tx_serial_cfg_if #(.DATA_BITS(8)) ifb ();
   tx_serial_cfg_if #(.DATA_BITS(5)) ifc ();

   assign ifa.partida = partida && (sel == 0);
   assign ifb.partida = partida && (sel == 1);
   assign ifc.partida = partida && (sel == 2);
   assign ifa.dados   = dados[6:0];
   assign ifb.dados   = dados;
   assign ifc.dados   = dados[4:0];

   tx_serial_cfg #(
      .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .BAUD_DIV(4)
   ) u_a (.clock(clk), .reset(rst), .tx(ifa));

   tx_serial_cfg #(
      .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .BAUD_DIV(4)
   ) u_b (.clock(clk), .reset(rst), .tx(ifb));

   tx_serial_cfg #(
      .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .BAUD_DIV(3)
   ) u_c (.clock(clk), .reset(rst), .tx(ifc));

   // {line, ocupado, pronto, estado[1:0]}
   function automatic logic [4:0] obs(input int s);
      case (s)
         0: return {ifa.saida_serial, ifa.ocupado,
                    ifa.pronto, ifa.db_estado};
         1: return {ifb.saida_serial, ifb.ocupado,
                    ifb.pronto, ifb.db_estado};
         default: return {ifc.saida_serial, ifc.ocupado,
                          ifc.pronto, ifc.db_estado};
      endcase
   endfunction

   function automatic logic exp_bit(
      input logic [7:0] d,
      input int db,
      input int par,
      input int k
   );
      int ones;
      ones = $countones(d & 8'((1 << db) - 1));
      if (k == 0) return 1'b0;
      if (k <= db) return d[k-1];
      if (par != 0 && k == db + 1)
         return ((ones % 2) == 1) ^ (par == 2);
      return 1'b1;
   endfunction

   task automatic chk(
      input string tag,
      input logic [7:0] o,
      input logic [7:0] e
   );
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   // mode 0 plain, 1 mid-frame disturbance, 2 reset at t+10
   task automatic run(
      input int s,
      input logic [7:0] d,
      input int nf,
      input int mode
   );
      int db, par, b, n, p, win, npr;
      db  = DBV[s];
      par = PARV[s];
      b   = BDV[s];
      n   = 1 + db + ((par != 0) ? 1 : 0) + SBV[s];
      p   = n * b + 2;
      win = nf * p + 6;
      npr = 0;
      @(posedge clk); #1;
      sel = s;
      partida = 1'b1;
      dados = d;
      @(posedge clk); #1;
      for (int off = 0; off < win; off++) begin
         int f, r;
         logic el, eo, ep;
         logic [1:0] es;
         logic [4:0] o;
         @(negedge clk);
         f = off / p;
         r = off % p;
         el = 1'b1; eo = 1'b0; ep = 1'b0; es = 2'd0;
         if (!(mode == 2 && off >= 11) && f < nf) begin
            if (r >= 1 && r <= n * b) begin
               el = exp_bit(d, db, par, (r - 1) / b);
               eo = 1'b1;
               es = 2'd1;
            end else if (r == n * b + 1) begin
               eo = 1'b1;
               ep = 1'b1;
               es = 2'd2;
            end
         end
         o = obs(s);
         if (o[2] === 1'b1) npr++;
         chk($sformatf("line s%0d off%0d", s, off),
             8'(o[4]), 8'(el));
         chk($sformatf("ocupado s%0d off%0d", s, off),
             8'(o[3]), 8'(eo));
         chk($sformatf("pronto s%0d off%0d", s, off),
             8'(o[2]), 8'(ep));
         chk($sformatf("estado s%0d off%0d", s, off),
             8'(o[1:0]), 8'(es));
         if (off == (nf - 1) * p) partida = 1'b0;
         if (mode == 1 && off == 5) begin
            partida = 1'b1;
            dados = 8'($urandom);
         end
         if (mode == 1 && off == 20) partida = 1'b0;
         if (mode == 2 && off == 10) rst = 1'b1;
         if (mode == 2 && off == 11) rst = 1'b0;
      end
      chk($sformatf("npronto s%0d", s), 8'(npr),
          8'((mode == 2) ? 0 : nf));
   endtask

   initial begin
      rst = 1'b1;
      partida = 1'b0;
      dados = 8'h00;
      sel = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         logic [4:0] o;
         o = obs(s);
         chk($sformatf("rst line s%0d", s), 8'(o[4]), 8'd1);
         chk($sformatf("rst ocupado s%0d", s), 8'(o[3]), 8'd0);
         chk($sformatf("rst pronto s%0d", s), 8'(o[2]), 8'd0);
         chk($sformatf("rst estado s%0d", s), 8'(o[1:0]), 8'd0);
      end

      run(0, 8'h41, 1, 0);
      run(1, 8'hFF, 1, 0);
      run(2, 8'h16, 1, 0);
      run(0, 8'h2A, 1, 1);
      run(0, 8'h55, 1, 2);
      run(0, 8'h63, 1, 0);
      run(0, 8'h41, 3, 0);
      for (int i = 0; i < 6; i++)
         run(i % 3, 8'($urandom), 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tx_serial_cfg.md
# tx_serial_cfg

Parametrised asynchronous serial transmitter: frames a parallel word with start bit, configurable data width, optional even/odd parity and one or two stop bits, and shifts it out LSB-first at a fixed baud rate. It includes its own control FSM, baud-tick counter and bit counter, and exposes a start/ready handshake. It is the generalised successor of the fixed 7E1 transmit datapath and drops in wherever the design sends characters or pixel bytes to a host UART.

## Interface

- `DATA_BITS`, 7: data bits per frame, legal range 5..8.
- `PARITY`, 1: parity mode. 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `BAUD_DIV`, 434: clock cycles per bit, ≥ 2 (434 gives 115200 baud at 50 MHz).
- Illegal parameter values cause an elaboration error.

- `clock` in 1: single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `partida` in 1: start request; sampled only in INICIAL.
- `dados` in DATA_BITS: word to send; captured on the cycle `partida` is accepted.
- `saida_serial` out 1: serial line, idle high, registered.
- `ocupado` out 1: high from acceptance through the FINAL state.
- `pronto` out 1: one-cycle pulse when a frame completes.
- `db_estado` out 2: current FSM state, for debug.

## Operation

- Frame length N = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS, ranging 7..12.
- Frame order on the line: start bit 0, then `dados[0]`..`dados[DATA_BITS-1]`, then parity bit if enabled, then stop bits at 1.
- Parity bit: even = ^dados; odd = ~^dados. It is computed from the captured word.
- FSM states:
  - INICIAL: idle, line 1. Moves to TRANSMISSAO when `partida`=1; the frame shift register loads in that same cycle.
  - TRANSMISSAO: holds each bit for BAUD_DIV cycles, then shifts in 1. Moves to FINAL when the bit counter reaches N and the baud counter ends.
  - FINAL: one cycle. `pronto`=1, line 1, `ocupado`=1. Always returns to INICIAL.
- `partida` is ignored outside INICIAL, and no request is queued. `dados` changes after acceptance have no effect.
- `partida` held high continuously starts a new frame each time INICIAL is re-entered.
- Reset at any time, including mid-frame: next cycle `saida_serial`=1, `ocupado`=0, `pronto`=0, state INICIAL. The frame is abandoned and no `pronto` is issued.

## Timing

- Reset values: `saida_serial`=1, `ocupado`=0, `pronto`=0, `db_estado`=INICIAL. Baud and bit counters are 0.
- `partida` accepted at edge t:
  - start bit appears on `saida_serial` at t+1;
  - bit k occupies cycles t+1+k·BAUD_DIV .. t+(k+1)·BAUD_DIV.
- The last stop bit ends at t+N·BAUD_DIV. FINAL / `pronto` occupies cycle t+N·BAUD_DIV+1, and INICIAL follows at t+N·BAUD_DIV+2.
- Minimum spacing between accepted starts is N·BAUD_DIV+2 cycles. The line stays 1 during the gap.
- `ocupado` rises at t+1 and falls at t+N·BAUD_DIV+2.
- Width rules: baud counter is $clog2(BAUD_DIV) bits; bit counter is 4 bits; shift register is N bits wide.

## Structure

- Package `tx_serial_pkg`:
  - state encoding: INICIAL=0, TRANSMISSAO=1, FINAL=2;
  - parity-mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - a function returning N from the parameters.
- Sub-module: baud and bit counting reuse the existing `contador_m`. One instance has M=BAUD_DIV, one has M=N, and the FSM drives their zera_s/conta inputs.
- Shift register and frame composition are written inline in the block.

## Test plan

- Defaults with BAUD_DIV=4, `dados`=7'h41, `partida` pulse at t:
  - line samples 0,1,0,0,0,0,0,1,0,1, one per 4 cycles starting at t+1;
  - `pronto` at t+41.
- DATA_BITS=8, PARITY=2, STOP_BITS=2, BAUD_DIV=4, `dados`=8'hFF:
  - frame 0, eight 1s, parity 1, 1, 1 (N=12);
  - `pronto` at t+49.
- DATA_BITS=5, PARITY=0, BAUD_DIV=3, `dados`=5'b10110:
  - frame 0,0,1,1,0,1,1 (N=7);
  - `ocupado` high t+1..t+22.
- `partida` pulsed again mid-frame, and `dados` changed mid-frame:
  - the frame is unaltered;
  - exactly one `pronto`;
  - no second frame starts.
- Reset asserted at t+10 of a default-parameter frame:
  - `saida_serial`=1 and `ocupado`=0 at t+11;
  - no `pronto`;
  - a fresh `partida` afterwards yields a correct full frame.
- `partida` held high, defaults, BAUD_DIV=4:
  - successive start bits begin 42 cycles apart;
  - `pronto` pulses every 42 cycles.
